// File: rtl/axi_burst_write_master_if.sv
// AXI write-channel bundle (AW, W, B) between the burst write master and a slave.
interface axi_burst_write_master_if #(
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_burst_write_master.sv
// Single-outstanding AXI INCR burst writer: streams 16-bit local samples into
// the slave RAM, one burst per accepted command, through a one-entry W buffer.
module axi_burst_write_master #(
  parameter int ADDR_W   = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic                    a_clk,
  input  logic                    a_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [SAMPLE_W-1:0]     wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    done,
  output logic                    err,
  axi_burst_write_master_if.master m_axi
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_awvalid;
  logic [ADDR_W-1:0]     r_awaddr;
  logic [3:0]            r_awlen;
  logic                  r_wvalid;
  logic [SAMPLE_W-1:0]   r_wdata;
  logic                  r_wlast;
  logic                  r_bready;
  logic                  r_done;
  logic                  r_err;
  logic [3:0]            r_beat_cnt;
  logic                  r_all_loaded;

  logic                  w_cmd_hs;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_wr_ready;
  logic                  w_load;
  logic                  w_last_load;

  assign cmd_ready   = (r_state == S_IDLE);
  assign w_cmd_hs    = cmd_valid && cmd_ready;
  assign w_aw_hs     = r_awvalid && m_axi.awready;
  assign w_w_hs      = r_wvalid && m_axi.wready;
  assign w_b_hs      = r_bready && m_axi.bvalid;
  // r_all_loaded stands in for "loads <= awlen" so a 16-beat burst works with a 4-bit counter
  assign w_wr_ready  = (r_state == S_DATA) && (!r_wvalid || m_axi.wready) && !r_all_loaded;
  assign w_load      = wr_valid && w_wr_ready;
  assign w_last_load = (r_beat_cnt == r_awlen);

  assign wr_ready      = w_wr_ready;
  assign done          = r_done;
  assign err           = r_err;

  assign m_axi.awvalid = r_awvalid;
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awlen   = r_awlen;
  assign m_axi.awsize  = 3'b001;
  assign m_axi.awburst = 2'b01;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wdata   = {{(64-SAMPLE_W){1'b0}}, r_wdata};
  assign m_axi.wstrb   = 8'h03;
  assign m_axi.wlast   = r_wlast;
  assign m_axi.bready  = r_bready;

  // State register
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) w_next_state = S_ADDR;
        else          w_next_state = S_IDLE;
      end
      S_ADDR: begin
        if (w_aw_hs) w_next_state = S_DATA;
        else         w_next_state = S_ADDR;
      end
      S_DATA: begin
        if (w_w_hs && r_wlast) w_next_state = S_RESP;
        else                   w_next_state = S_DATA;
      end
      S_RESP: begin
        if (w_b_hs) w_next_state = S_IDLE;
        else        w_next_state = S_RESP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Channel registers, holding buffer and beat bookkeeping
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      r_awvalid    <= 1'b0;
      r_awaddr     <= {ADDR_W{1'b0}};
      r_awlen      <= 4'd0;
      r_wvalid     <= 1'b0;
      r_wdata      <= {SAMPLE_W{1'b0}};
      r_wlast      <= 1'b0;
      r_bready     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_beat_cnt   <= 4'd0;
      r_all_loaded <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_awaddr     <= cmd_addr;
            r_awlen      <= cmd_len;
            r_awvalid    <= 1'b1;
            r_err        <= 1'b0;
            r_beat_cnt   <= 4'd0;
            r_all_loaded <= 1'b0;
          end
        end
        S_ADDR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
        end
        S_DATA: begin
          // A load can coincide with the W handshake, giving one beat per cycle
          if (w_load) begin
            r_wdata    <= wr_data;
            r_wvalid   <= 1'b1;
            r_wlast    <= w_last_load;
            r_beat_cnt <= r_beat_cnt + 4'd1;
            if (w_last_load) r_all_loaded <= 1'b1;
          end else if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            if (r_wlast) r_bready <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= (m_axi.bresp != 2'b00);
          end
        end
        default: begin
          r_bready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: drives the AXI slave side by hand
// and keeps a small RAM model fed from observed W handshakes.
module tb_axi_burst_write_master;

  logic        a_clk = 1'b0;
  logic        a_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_beats  = 0;

  logic [15:0] mem [0:255];
  logic [7:0]  mon_base;
  logic [3:0]  mon_idx;

  axi_burst_write_master_if #(.ADDR_W(32)) axi ();

  axi_burst_write_master #(.ADDR_W(32), .SAMPLE_W(16)) dut (
    .a_clk     (a_clk),
    .a_rst     (a_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .done      (done),
    .err       (err),
    .m_axi     (axi)
  );

  always #5 a_clk = ~a_clk;

  // Slave RAM model and event counters
  always @(posedge a_clk) begin
    if (axi.awvalid && axi.awready) begin
      mon_base <= axi.awaddr[7:0];
      mon_idx  <= 4'd0;
      n_beats  <= 0;
    end
    if (axi.wvalid && axi.wready) begin
      mem[mon_base + {4'd0, mon_idx}] <= axi.wdata[15:0];
      mon_idx <= mon_idx + 4'd1;
      n_beats <= n_beats + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge a_clk);
  endtask

  task automatic do_cmd(input logic [31:0] addr, input logic [3:0] len, input int aw_delay);
    step();
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_len   = 4'hF;
    for (int i = 0; i < aw_delay; i++) begin
      chk("awvalid_hold", axi.awvalid, 1);
      chk("awaddr_hold", axi.awaddr, addr);
      step();
    end
    chk("awvalid", axi.awvalid, 1);
    chk("awaddr", axi.awaddr, addr);
    chk("awlen", axi.awlen, len);
    chk("awsize", axi.awsize, 3'b001);
    chk("awburst", axi.awburst, 2'b01);
    chk("err_clr_on_accept", err, 0);
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("wvalid_before_aw", axi.wvalid, 0);
    axi.awready = 1'b1;
    #1 chk("wr_ready_in_addr", wr_ready, 0);
    step();
    axi.awready = 1'b0;
    chk("awvalid_drop", axi.awvalid, 0);
  endtask

  task automatic finish_resp(input logic [1:0] resp, input logic exp_err, input int delay);
    for (int i = 0; i < delay; i++) begin
      chk("bready_wait", axi.bready, 1);
      chk("done_wait", done, 0);
      step();
    end
    axi.bvalid = 1'b1;
    axi.bresp  = resp;
    step();
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    chk("done_pulse", done, 1);
    chk("err_with_done", err, exp_err);
    chk("bready_drop", axi.bready, 0);
    chk("cmd_ready_at_done", cmd_ready, 1);
    step();
    chk("done_one_cycle", done, 0);
    chk("err_held", err, exp_err);
  endtask

  initial begin
    a_rst       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = 32'd0;
    cmd_len     = 4'd0;
    wr_data     = 16'd0;
    wr_valid    = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    repeat (2) step();
    a_rst = 1'b0;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_wlast", axi.wlast, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_awaddr", axi.awaddr, 0);
    chk("rst_awlen", axi.awlen, 0);
    chk("rst_wdata", axi.wdata, 0);

    // Burst 1: three back-to-back beats at 0x0A
    do_cmd(32'h0000_000A, 4'd2, 2);
    wr_valid   = 1'b1;
    wr_data    = 16'hABCD;
    axi.wready = 1'b1;
    #1 chk("t1_wr_ready", wr_ready, 1);
    step();
    chk("t1_b0_wvalid", axi.wvalid, 1);
    chk("t1_b0_wdata", axi.wdata, 64'h0000_0000_0000_ABCD);
    chk("t1_b0_wlast", axi.wlast, 0);
    chk("t1_wstrb", axi.wstrb, 8'h03);
    wr_data = 16'hFDDF;
    step();
    chk("t1_b1_wdata", axi.wdata, 64'h0000_0000_0000_FDDF);
    chk("t1_b1_wlast", axi.wlast, 0);
    wr_data = 16'hFAFA;
    step();
    chk("t1_b2_wdata", axi.wdata, 64'h0000_0000_0000_FAFA);
    chk("t1_b2_wlast", axi.wlast, 1);
    wr_data = 16'h9999;
    #1 chk("t1_no_extra_take", wr_ready, 0);
    step();
    wr_valid = 1'b0;
    chk("t1_wvalid_end", axi.wvalid, 0);
    chk("t1_wlast_end", axi.wlast, 0);
    chk("t1_bready", axi.bready, 1);
    chk("t1_beats", n_beats, 3);
    finish_resp(2'b00, 1'b0, 2);
    chk("t1_mem0", mem[8'h0A], 16'hABCD);
    chk("t1_mem1", mem[8'h0B], 16'hFDDF);
    chk("t1_mem2", mem[8'h0C], 16'hFAFA);

    // Burst 2: single beat
    do_cmd(32'h0000_0020, 4'd0, 0);
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    step();
    wr_valid = 1'b0;
    chk("t2_wvalid", axi.wvalid, 1);
    chk("t2_wlast", axi.wlast, 1);
    chk("t2_wdata", axi.wdata, 64'h0000_0000_0000_1234);
    step();
    chk("t2_bready", axi.bready, 1);
    chk("t2_beats", n_beats, 1);
    finish_resp(2'b00, 1'b0, 0);
    chk("t2_mem", mem[8'h20], 16'h1234);

    // Burst 3: local source gaps
    do_cmd(32'h0000_0030, 4'd2, 0);
    wr_valid = 1'b1;
    wr_data  = 16'h1111;
    step();
    wr_valid = 1'b0;
    chk("t3_b0_wdata", axi.wdata, 64'h0000_0000_0000_1111);
    step();
    chk("t3_gap1_wvalid", axi.wvalid, 0);
    step();
    chk("t3_gap2_wvalid", axi.wvalid, 0);
    wr_valid = 1'b1;
    wr_data  = 16'h2222;
    step();
    chk("t3_b1_wdata", axi.wdata, 64'h0000_0000_0000_2222);
    chk("t3_b1_wlast", axi.wlast, 0);
    wr_data = 16'h3333;
    step();
    wr_valid = 1'b0;
    chk("t3_b2_wdata", axi.wdata, 64'h0000_0000_0000_3333);
    chk("t3_b2_wlast", axi.wlast, 1);
    step();
    chk("t3_bready", axi.bready, 1);
    chk("t3_beats", n_beats, 3);
    finish_resp(2'b00, 1'b0, 0);
    chk("t3_mem0", mem[8'h30], 16'h1111);
    chk("t3_mem1", mem[8'h31], 16'h2222);
    chk("t3_mem2", mem[8'h32], 16'h3333);

    // Burst 4: wready stall on beat 2, early bvalid ignored, SLVERR response
    do_cmd(32'h0000_0040, 4'd2, 0);
    wr_valid = 1'b1;
    wr_data  = 16'h00A1;
    step();
    wr_data = 16'h00A2;
    step();
    chk("t4_b1_wdata", axi.wdata, 64'h0000_0000_0000_00A2);
    axi.wready = 1'b0;
    axi.bvalid = 1'b1;
    axi.bresp  = 2'b10;
    wr_data    = 16'h00A3;
    #1 chk("t4_wr_ready_full", wr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_wvalid", axi.wvalid, 1);
      chk("t4_stall_wdata", axi.wdata, 64'h0000_0000_0000_00A2);
      chk("t4_stall_wlast", axi.wlast, 0);
      chk("t4_stall_wr_ready", wr_ready, 0);
      chk("t4_early_b_ignored", axi.bready, 0);
    end
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    axi.wready = 1'b1;
    #1 chk("t4_wr_ready_drain", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    chk("t4_b2_wdata", axi.wdata, 64'h0000_0000_0000_00A3);
    chk("t4_b2_wlast", axi.wlast, 1);
    step();
    chk("t4_beats", n_beats, 3);
    finish_resp(2'b10, 1'b1, 0);
    step();
    chk("t4_err_sticky", err, 1);
    chk("t4_mem0", mem[8'h40], 16'h00A1);
    chk("t4_mem1", mem[8'h41], 16'h00A2);
    chk("t4_mem2", mem[8'h42], 16'h00A3);

    // Burst 5: reset after the first of three beats, err cleared on accept
    do_cmd(32'h0000_0050, 4'd2, 0);
    wr_valid = 1'b1;
    wr_data  = 16'h00B1;
    step();
    wr_valid = 1'b0;
    step();
    chk("t5_beats_before_rst", n_beats, 1);
    #2 a_rst = 1'b1;
    #1;
    chk("t5_rst_awvalid", axi.awvalid, 0);
    chk("t5_rst_wvalid", axi.wvalid, 0);
    chk("t5_rst_wlast", axi.wlast, 0);
    chk("t5_rst_bready", axi.bready, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_wr_ready", wr_ready, 0);
    chk("t5_rst_wdata", axi.wdata, 0);
    chk("t5_rst_awaddr", axi.awaddr, 0);
    step();
    a_rst = 1'b0;
    step();
    chk("t5_post_rst_cmd_ready", cmd_ready, 1);
    chk("t5_post_rst_done", done, 0);

    do_cmd(32'h0000_0060, 4'd1, 0);
    wr_valid = 1'b1;
    wr_data  = 16'h00C1;
    step();
    wr_data = 16'h00C2;
    step();
    wr_valid = 1'b0;
    chk("t6_b1_wdata", axi.wdata, 64'h0000_0000_0000_00C2);
    chk("t6_b1_wlast", axi.wlast, 1);
    step();
    chk("t6_bready", axi.bready, 1);
    finish_resp(2'b00, 1'b0, 1);
    chk("t6_mem0", mem[8'h60], 16'h00C1);
    chk("t6_mem1", mem[8'h61], 16'h00C2);
    chk("total_done_pulses", n_done, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
